data_memory: RTL and testbench

Clocked, parametrised word memory with valid/ready request and response channels, byte-enable writes, configurable read latency, and per-request address error reporting. It is the next generation of the processor's data/instruction memory: it replaces the start-edge-triggered memory with a single-clock pipelined block that the MIPS datapath and the memory-stage controller talk to through handshakes. Every accepted request, read or write, produces exactly one in-order response.

---
 rtl/data_memory.sv | 171 +++++++++++++++++
 tb/tb_data_memory.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word memory with a valid/ready request and response interface, byte-enable writes,
// a fixed-latency read pipeline and per-request address error reporting.
module data_memory #(
    parameter int WORD_SIZE      = 32,
    parameter int MEMORY_DEPTH   = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int BYTE_ADDRESSED = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [WORD_SIZE-1:0]   req_addr,
    input  logic [WORD_SIZE-1:0]   req_wdata,
    input  logic [WORD_SIZE/8-1:0] req_byte_en,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WORD_SIZE-1:0]   resp_rdata,
    output logic                   resp_err
);

    localparam int NB    = WORD_SIZE / 8;
    localparam int BS    = $clog2(NB);
    localparam int AW    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int DEPTH = READ_LATENCY + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam logic [WORD_SIZE-1:0] LOW_MASK = WORD_SIZE'((1 << BS) - 1);
    localparam logic [WORD_SIZE-1:0] DEPTH_W  = WORD_SIZE'(MEMORY_DEPTH);

    logic [WORD_SIZE-1:0] w_idx_full;
    logic [AW-1:0]        w_idx;
    logic                 w_misaligned;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_wr_en;
    logic                 w_rd_en;

    always_comb begin
        w_idx_full   = req_addr;
        w_misaligned = 1'b0;
        if (BYTE_ADDRESSED != 0) begin
            w_idx_full   = req_addr >> BS;
            w_misaligned = (req_addr & LOW_MASK) != '0;
        end
    end

    assign w_idx    = w_idx_full[AW-1:0];
    assign w_err    = w_misaligned || (w_idx_full >= DEPTH_W);
    assign w_accept = req_valid && req_ready;
    assign w_wr_en  = w_accept && req_write && !w_err;
    assign w_rd_en  = w_accept && !req_write && !w_err;

    // Storage has no reset so it maps onto block RAM; contents survive reset_n.
    logic [WORD_SIZE-1:0] r_mem [MEMORY_DEPTH];
    logic [WORD_SIZE-1:0] r_mem_q;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (req_byte_en[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
        if (w_rd_en) begin
            r_mem_q <= r_mem[w_idx];
        end
    end

    logic                 w_pv    [READ_LATENCY];
    logic                 w_perr  [READ_LATENCY];
    logic [WORD_SIZE-1:0] w_pdata [READ_LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                logic r_valid;
                logic r_err;
                logic r_use_mem;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_valid   <= 1'b0;
                        r_err     <= 1'b0;
                        r_use_mem <= 1'b0;
                    end else begin
                        r_valid   <= w_accept;
                        r_err     <= w_err;
                        r_use_mem <= w_rd_en;
                    end
                end

                // Writes and errored requests answer with zero data.
                assign w_pv[gi]    = r_valid;
                assign w_perr[gi]  = r_err;
                assign w_pdata[gi] = r_use_mem ? r_mem_q : '0;
            end else begin : g_tail
                logic                 r_valid;
                logic                 r_err;
                logic [WORD_SIZE-1:0] r_data;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                        r_data  <= '0;
                    end else begin
                        r_valid <= w_pv[gi-1];
                        r_err   <= w_perr[gi-1];
                        r_data  <= w_pdata[gi-1];
                    end
                end

                assign w_pv[gi]    = r_valid;
                assign w_perr[gi]  = r_err;
                assign w_pdata[gi] = r_data;
            end
        end
    endgenerate

    // The credit counter caps pipeline plus FIFO occupancy at DEPTH, so a push never finds it full.
    logic [WORD_SIZE-1:0] r_fifo_data [DEPTH];
    logic                 r_fifo_err  [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_fifo_cnt;
    logic [CW-1:0]        r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push = w_pv[READ_LATENCY-1];
    assign w_pop  = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_pdata[READ_LATENCY-1];
            r_fifo_err[r_wr_ptr]  <= w_perr[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
            r_count    <= r_count + CW'(w_accept) - CW'(w_pop);
        end
    end

    assign req_ready  = r_count < CW'(DEPTH);
    assign resp_valid = r_fifo_cnt != '0;
    assign resp_rdata = resp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign resp_err   = resp_valid && r_fifo_err[r_rd_ptr];

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: three instances (read latency 1, 2, 3) checked against
// fixed vectors and a word-array/queue reference model under random traffic.
module tb_data_memory;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req_valid   [NI];
    logic        req_ready   [NI];
    logic        req_write   [NI];
    logic [31:0] req_addr    [NI];
    logic [31:0] req_wdata   [NI];
    logic [3:0]  req_byte_en [NI];
    logic        resp_valid  [NI];
    logic        resp_ready  [NI];
    logic [31:0] resp_rdata  [NI];
    logic        resp_err    [NI];

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            data_memory #(
                .WORD_SIZE(32),
                .MEMORY_DEPTH(1024),
                .READ_LATENCY(gi + 1),
                .BYTE_ADDRESSED(1)
            ) u_dut (
                .clk(clk),
                .reset_n(reset_n),
                .req_valid(req_valid[gi]),
                .req_ready(req_ready[gi]),
                .req_write(req_write[gi]),
                .req_addr(req_addr[gi]),
                .req_wdata(req_wdata[gi]),
                .req_byte_en(req_byte_en[gi]),
                .resp_valid(resp_valid[gi]),
                .resp_ready(resp_ready[gi]),
                .resp_rdata(resp_rdata[gi]),
                .resp_err(resp_err[gi])
            );
        end
    endgenerate

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          chk;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl_mem   [NI][1024];
    bit          mdl_known [NI][1024];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_pop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour: word address = addr/4, error if unaligned or beyond 1024 words.
    task automatic model_apply(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, output exp_t e);
        int unsigned idx;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.chk   = 1'b1;
        if ((addr % 4) != 0 || (addr / 4) >= 1024) begin
            e.err = 1'b1;
            return;
        end
        idx = addr / 4;
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdl_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (be == 4'hF) mdl_known[d][idx] = 1'b1;
        end else begin
            e.rdata = mdl_mem[d][idx];
            e.chk   = mdl_known[d][idx];
        end
    endtask

    // One clock of scoreboarded traffic on instance d; called between edges with inputs set.
    task automatic step(input int d);
        bit   acc;
        bit   pop;
        exp_t e;
        acc = req_valid[d] && req_ready[d];
        pop = resp_valid[d] && resp_ready[d];
        chk($sformatf("req_ready[%0d]", d), 32'(req_ready[d]), 32'(exp_q.size() < d + 2));
        if (exp_q.size() == 0) begin
            chk($sformatf("spurious_resp[%0d]", d), 32'(resp_valid[d]), 32'h0);
        end else if (pop) begin
            e = exp_q.pop_front();
            n_pop++;
            $display("resp inst%0d rdata=%08h err=%0d", d, resp_rdata[d], resp_err[d]);
            if (e.chk) chk($sformatf("rdata[%0d]", d), resp_rdata[d], e.rdata);
            chk($sformatf("err[%0d]", d), 32'(resp_err[d]), 32'(e.err));
        end
        if (acc) begin
            model_apply(d, req_write[d], req_addr[d], req_wdata[d], req_byte_en[d], e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int d);
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(d);
        chk($sformatf("drain_left[%0d]", d), 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    // Single request with exact latency checks against a table entry.
    task automatic apply_vec(input int d, input vec_t v);
        exp_t e;
        req_valid[d]   = 1'b1;
        req_write[d]   = v.wr;
        req_addr[d]    = v.addr;
        req_wdata[d]   = v.wdata;
        req_byte_en[d] = v.be;
        resp_ready[d]  = 1'b1;
        chk($sformatf("vec_ready[%0d]", d), 32'(req_ready[d]), 32'h1);
        model_apply(d, v.wr, v.addr, v.wdata, v.be, e);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        for (int c = 0; c < d + 1; c++) begin
            chk($sformatf("vec_early_valid[%0d]", d), 32'(resp_valid[d]), 32'h0);
            @(posedge clk);
            #1;
        end
        $display("vec inst%0d %s addr=%08h rdata=%08h err=%0d", d, v.wr ? "W" : "R",
                 v.addr, resp_rdata[d], resp_err[d]);
        chk($sformatf("vec_valid[%0d]", d), 32'(resp_valid[d]), 32'h1);
        chk($sformatf("vec_rdata[%0d]", d), resp_rdata[d], v.exp_rdata);
        chk($sformatf("vec_err[%0d]", d), 32'(resp_err[d]), 32'(v.exp_err));
        @(posedge clk);
        #1;
        chk($sformatf("vec_popped[%0d]", d), 32'(resp_valid[d]), 32'h0);
    endtask

    task automatic rand_run(input int d, input int n, input logic [31:0] base);
        int sel;
        for (int i = 0; i < n; i++) begin
            req_valid[d]   = ($urandom_range(0, 3) != 0);
            resp_ready[d]  = ($urandom_range(0, 3) != 0);
            req_write[d]   = 1'($urandom_range(0, 1));
            sel            = $urandom_range(0, 9);
            req_addr[d]    = base + 32'(4 * $urandom_range(0, 15));
            if (sel == 8) req_addr[d] = req_addr[d] + 32'($urandom_range(1, 3));
            if (sel == 9) req_addr[d] = 32'h1000 + 32'(4 * $urandom_range(0, 100));
            req_wdata[d]   = $urandom;
            req_byte_en[d] = 4'($urandom_range(0, 15));
            step(d);
        end
        drain(d);
    endtask

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        int   pops0;
        bit   was_ready;
        vec_t rv;

        tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{1'b0, 32'h13,       32'h0,        4'h0, 32'h0,        1'b1};
        tbl[6]  = '{1'b1, 32'h0,        32'h12345678, 4'hF, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h12345678, 1'b0};
        tbl[9]  = '{1'b1, 32'h22,       32'h0,        4'hF, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tbl[11] = '{1'b1, 32'hFFC,      32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 32'hFFC,      32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        tbl[13] = '{1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1};
        tbl[14] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};

        reset_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req_valid[i]   = 1'b0;
            resp_ready[i]  = 1'b1;
            req_write[i]   = 1'b0;
            req_addr[i]    = 32'h0;
            req_wdata[i]   = 32'h0;
            req_byte_en[i] = 4'h0;
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_resp_valid[%0d]", i), 32'(resp_valid[i]), 32'h0);
            chk($sformatf("rst_resp_rdata[%0d]", i), resp_rdata[i], 32'h0);
            chk($sformatf("rst_resp_err[%0d]", i), 32'(resp_err[i]), 32'h0);
            chk($sformatf("rst_req_ready[%0d]", i), 32'(req_ready[i]), 32'h1);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors at latency 1 and latency 3.
        for (int i = 0; i < 15; i++) apply_vec(0, tbl[i]);
        for (int i = 0; i < 15; i++) apply_vec(2, tbl[i]);

        // Random traffic against the reference model.
        rand_run(0, 300, 32'h100);
        rand_run(2, 300, 32'h100);

        // Backpressure at latency 3: four credits, then stall until the first pop.
        for (int i = 0; i < 6; i++) begin
            req_valid[2]   = 1'b1;
            req_write[2]   = 1'b1;
            req_addr[2]    = 32'h300 + 32'(4 * i);
            req_wdata[2]   = $urandom;
            req_byte_en[2] = 4'hF;
            resp_ready[2]  = 1'b1;
            for (int t = 0; t < 10; t++) begin
                was_ready = req_ready[2];
                step(2);
                if (was_ready) break;
            end
        end
        drain(2);
        acc = 0;
        resp_ready[2] = 1'b0;
        req_write[2]  = 1'b0;
        for (int t = 0; t < 10; t++) begin
            req_valid[2] = 1'b1;
            req_addr[2]  = 32'h300 + 32'(4 * acc);
            was_ready    = req_ready[2];
            step(2);
            if (was_ready) acc++;
        end
        chk("bp_accepts", 32'(acc), 32'h4);
        chk("bp_ready_low", 32'(req_ready[2]), 32'h0);
        req_valid[2]  = 1'b0;
        resp_ready[2] = 1'b1;
        step(2);
        chk("bp_ready_back", 32'(req_ready[2]), 32'h1);
        drain(2);

        // Streaming at latency 2: preload 100 words, then 100 reads.
        for (int pass = 0; pass < 2; pass++) begin
            acc   = 0;
            pops0 = n_pop;
            resp_ready[1]  = 1'b1;
            req_write[1]   = (pass == 0);
            req_byte_en[1] = 4'hF;
            for (int t = 0; t < 400 && acc < 100; t++) begin
                req_valid[1] = 1'b1;
                req_addr[1]  = 32'h600 + 32'(4 * acc);
                req_wdata[1] = $urandom;
                was_ready    = req_ready[1];
                step(1);
                if (was_ready) acc++;
            end
            drain(1);
            chk($sformatf("stream_accepts_pass%0d", pass), 32'(acc), 32'd100);
            chk($sformatf("stream_resps_pass%0d", pass), 32'(n_pop - pops0), 32'd100);
        end

        // Reset with two requests in flight at latency 1.
        rv = '{1'b1, 32'h40, 32'h5A5A1234, 4'hF, 32'h0, 1'b0};
        apply_vec(0, rv);
        resp_ready[0] = 1'b0;
        req_write[0]  = 1'b0;
        req_addr[0]   = 32'h40;
        req_valid[0]  = 1'b1;
        step(0);
        step(0);
        chk("pre_reset_valid", 32'(resp_valid[0]), 32'h1);
        #2;
        reset_n      = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        chk("mid_reset_valid", 32'(resp_valid[0]), 32'h0);
        chk("mid_reset_rdata", resp_rdata[0], 32'h0);
        chk("mid_reset_err", 32'(resp_err[0]), 32'h0);
        chk("mid_reset_ready", 32'(req_ready[0]), 32'h1);
        exp_q.delete();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[0] = 1'b1;
        for (int i = 0; i < 5; i++) step(0);
        rv = '{1'b0, 32'h40, 32'h0, 4'h0, 32'h5A5A1234, 1'b0};
        apply_vec(0, rv);
        rv = '{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        apply_vec(2, rv);
        rv = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0};
        apply_vec(0, rv);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h600 + 32'(4 * 57);
        step(1);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
